// File: rtl/fwd_pkg.sv
// Shared constants for the forwarding/hazard controller: default widths and
// the EX operand mux select codes (Muxfa6 input numbering).
package fwd_pkg;

  localparam int AW_DEF = 5;
  localparam int SW_DEF = 3;

  typedef logic [SW_DEF-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 3'd0;
  localparam fwd_sel_t FWD_EXMEM = 3'd1;
  localparam fwd_sel_t FWD_MEMWB = 3'd2;
  localparam fwd_sel_t FWD_LINK  = 3'd3;

endpackage

// File: rtl/fwd_sel_gen.sv
// Combinational forwarding select for one EX operand, computed in decode from
// the producers currently in EX and MEM.
module fwd_sel_gen import fwd_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic [AW-1:0] reg_i,
  input  logic          use_i,
  input  logic [AW-1:0] ex_wa_i,
  input  logic          ex_we_i,
  input  logic          ex_link_i,
  input  logic [AW-1:0] mem_wa_i,
  input  logic          mem_we_i,
  output logic [SW-1:0] sel_o
);

  // The EX producer is newer than the MEM one, so it is checked first.
  always_comb begin
    sel_o = SW'(FWD_RF);
    if (use_i && (reg_i != '0)) begin
      if (ex_we_i && (ex_wa_i == reg_i)) begin
        sel_o = ex_link_i ? SW'(FWD_LINK) : SW'(FWD_EXMEM);
      end else if (mem_we_i && (mem_wa_i == reg_i)) begin
        sel_o = SW'(FWD_MEMWB);
      end
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
// Optional MDU busy stall for mfhi/mflo is enabled by defining FWD_MDU_STALL_EN.
module fwd_ctrl import fwd_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int SW = SW_DEF
`ifdef FWD_MDU_STALL_EN
  , parameter int MDU_LAT = 32
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  input  logic          id_use_rs_i,
  input  logic          id_use_rt_i,
  input  logic [AW-1:0] id_wa_i,
  input  logic          id_we_i,
  input  logic          id_load_i,
  input  logic          id_link_i,
  input  logic          flush_i,
`ifdef FWD_MDU_STALL_EN
  input  logic          id_mdu_start_i,
  input  logic          id_mdu_read_i,
`endif
  output logic          stall_o,
  output logic [SW-1:0] fwd_a_sel_o,
  output logic [SW-1:0] fwd_b_sel_o
);

  logic [AW-1:0] ex_wa_q, ex_wa_d, mem_wa_q;
  logic          ex_we_q, ex_we_d, mem_we_q;
  logic          ex_load_q, ex_load_d;
  logic          ex_link_q, ex_link_d;
  logic [SW-1:0] fwd_a_sel_q, fwd_a_sel_d;
  logic [SW-1:0] fwd_b_sel_q, fwd_b_sel_d;
  logic [SW-1:0] sel_a, sel_b;
  logic          load_use, stall_c, issue;

  // A load in EX cannot forward yet; hold the consumer one cycle and let it
  // pick the loaded value from MEM/WB instead.
  assign load_use = id_valid_i & ex_we_q & ex_load_q & (ex_wa_q != '0) &
                    ((id_use_rs_i & (id_rs_i == ex_wa_q)) |
                     (id_use_rt_i & (id_rt_i == ex_wa_q)));

`ifdef FWD_MDU_STALL_EN
  localparam int CW = $clog2(MDU_LAT + 1);
  logic [CW-1:0] mdu_cnt_q, mdu_cnt_d;
  logic          mdu_busy;

  assign mdu_busy = id_valid_i & id_mdu_read_i & (mdu_cnt_q != '0);
  assign stall_c  = ~flush_i & (load_use | mdu_busy);

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (issue && id_mdu_start_i) begin
      mdu_cnt_d = CW'(MDU_LAT);
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdu_cnt_q <= '0;
    else        mdu_cnt_q <= mdu_cnt_d;
  end
`else
  assign stall_c = ~flush_i & load_use;
`endif

  assign issue   = id_valid_i & ~flush_i & ~stall_c;
  assign stall_o = stall_c;

  fwd_sel_gen #(.AW(AW), .SW(SW)) u_sel_a (
    .reg_i    (id_rs_i),
    .use_i    (id_use_rs_i),
    .ex_wa_i  (ex_wa_q),
    .ex_we_i  (ex_we_q),
    .ex_link_i(ex_link_q),
    .mem_wa_i (mem_wa_q),
    .mem_we_i (mem_we_q),
    .sel_o    (sel_a)
  );

  fwd_sel_gen #(.AW(AW), .SW(SW)) u_sel_b (
    .reg_i    (id_rt_i),
    .use_i    (id_use_rt_i),
    .ex_wa_i  (ex_wa_q),
    .ex_we_i  (ex_we_q),
    .ex_link_i(ex_link_q),
    .mem_wa_i (mem_wa_q),
    .mem_we_i (mem_we_q),
    .sel_o    (sel_b)
  );

  // Anything that does not issue enters EX as a bubble with neutral selects.
  always_comb begin
    ex_wa_d     = ex_wa_q;
    ex_we_d     = 1'b0;
    ex_load_d   = 1'b0;
    ex_link_d   = 1'b0;
    fwd_a_sel_d = SW'(FWD_RF);
    fwd_b_sel_d = SW'(FWD_RF);
    if (issue) begin
      ex_wa_d     = id_wa_i;
      ex_we_d     = id_we_i;
      ex_load_d   = id_load_i;
      ex_link_d   = id_link_i;
      fwd_a_sel_d = sel_a;
      fwd_b_sel_d = sel_b;
    end
  end

  // MEM only needs address and write-enable: loads and links both reach
  // the MEM/WB result, so their flavour no longer affects selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_wa_q     <= '0;
      ex_we_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_link_q   <= 1'b0;
      mem_wa_q    <= '0;
      mem_we_q    <= 1'b0;
      fwd_a_sel_q <= '0;
      fwd_b_sel_q <= '0;
    end else begin
      ex_wa_q     <= ex_wa_d;
      ex_we_q     <= ex_we_d;
      ex_load_q   <= ex_load_d;
      ex_link_q   <= ex_link_d;
      mem_wa_q    <= ex_wa_q;
      mem_we_q    <= ex_we_q;
      fwd_a_sel_q <= fwd_a_sel_d;
      fwd_b_sel_q <= fwd_b_sel_d;
    end
  end

  assign fwd_a_sel_o = fwd_a_sel_q;
  assign fwd_b_sel_o = fwd_b_sel_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed vector table, reset corner cases,
// and randomized traffic against an in-flight instruction reference model.
module tb_fwd_ctrl;

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] wa;
    logic       we;
    logic       load;
    logic       link;
    logic       flush;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic       expStall;
    logic [2:0] expA;
    logic [2:0] expB;
  } vec_t;

  // One in-flight instruction as the reference model sees it.
  typedef struct {
    logic       we;
    logic       load;
    logic       link;
    logic [4:0] wa;
  } slot_t;

  logic       clk;
  logic       rst_n;
  logic       idValid, idUseRs, idUseRt, idWe, idLoad, idLink, flush;
  logic [4:0] idRs, idRt, idWa;
  logic       stall;
  logic [2:0] fwdA, fwdB;
`ifdef FWD_MDU_STALL_EN
  logic       mduStart, mduRead;
`endif

  int assertCount = 0;
  int failCount   = 0;

  // pipe[0] is the EX-stage instruction, pipe[1] the MEM-stage one.
  slot_t pipe[2];

  fwd_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid_i (idValid),
    .id_rs_i    (idRs),
    .id_rt_i    (idRt),
    .id_use_rs_i(idUseRs),
    .id_use_rt_i(idUseRt),
    .id_wa_i    (idWa),
    .id_we_i    (idWe),
    .id_load_i  (idLoad),
    .id_link_i  (idLink),
    .flush_i    (flush),
`ifdef FWD_MDU_STALL_EN
    .id_mdu_start_i(mduStart),
    .id_mdu_read_i (mduRead),
`endif
    .stall_o    (stall),
    .fwd_a_sel_o(fwdA),
    .fwd_b_sel_o(fwdB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mk(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic [4:0] wa,
                               input logic we, input logic load, input logic link,
                               input logic fl);
    stim_t s;
    s.valid = valid; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt;
    s.wa = wa; s.we = we; s.load = load; s.link = link; s.flush = fl;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    idValid = s.valid; idRs = s.rs; idRt = s.rt; idUseRs = s.urs; idUseRt = s.urt;
    idWa = s.wa; idWe = s.we; idLoad = s.load; idLink = s.link; flush = s.flush;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 2; i++) pipe[i] = '{we: 1'b0, load: 1'b0, link: 1'b0, wa: 5'd0};
  endfunction

  // Newest writer of r among in-flight instructions decides where the value lives.
  function automatic logic [2:0] modelCode(input logic [4:0] r, input logic u);
    if (!u || r == 5'd0) return 3'd0;
    for (int i = 0; i < 2; i++) begin
      if (pipe[i].we && pipe[i].wa == r) begin
        if (i == 0) return pipe[i].link ? 3'd3 : 3'd1;
        return 3'd2;
      end
    end
    return 3'd0;
  endfunction

  function automatic logic modelStall(input stim_t s);
    if (!s.valid || s.flush) return 1'b0;
    if (!(pipe[0].we && pipe[0].load) || pipe[0].wa == 5'd0) return 1'b0;
    return (s.urs && s.rs == pipe[0].wa) || (s.urt && s.rt == pipe[0].wa);
  endfunction

  function automatic void modelAdvance(input stim_t s, input logic issued);
    pipe[1] = pipe[0];
    if (issued) pipe[0] = '{we: s.we, load: s.load, link: s.link, wa: s.wa};
    else        pipe[0] = '{we: 1'b0, load: 1'b0, link: 1'b0, wa: pipe[0].wa};
  endfunction

  vec_t  vecs[20];
  stim_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idValid = 0; idRs = 0; idRt = 0; idUseRs = 0; idUseRt = 0;
    idWa = 0; idWe = 0; idLoad = 0; idLink = 0; flush = 0;
`ifdef FWD_MDU_STALL_EN
    mduStart = 0; mduRead = 0;
`endif
    modelReset();

    //            valid rs  rt urs urt wa we ld lk fl   stall A  B
    vecs[0]  = '{mk(1,  1,  2, 1, 1,  3, 1, 0, 0, 0), 0, 0, 0};
    vecs[1]  = '{mk(1,  3,  4, 1, 1,  6, 1, 0, 0, 0), 0, 1, 0};
    vecs[2]  = '{mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0), 0, 0, 0};
    vecs[3]  = '{mk(1,  0,  0, 1, 1,  3, 1, 0, 0, 0), 0, 0, 0};
    vecs[4]  = '{mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0), 0, 0, 0};
    vecs[5]  = '{mk(1,  5,  3, 1, 1,  7, 1, 0, 0, 0), 0, 0, 2};
    vecs[6]  = '{mk(1,  7,  7, 1, 1,  7, 1, 0, 0, 0), 0, 1, 1};
    vecs[7]  = '{mk(1,  7,  7, 1, 1,  8, 1, 0, 0, 0), 0, 1, 1};
    vecs[8]  = '{mk(1,  1,  0, 1, 0,  5, 1, 1, 0, 0), 0, 0, 0};
    vecs[9]  = '{mk(1,  5,  2, 1, 1,  9, 1, 0, 0, 0), 1, 0, 0};
    vecs[10] = '{mk(1,  5,  2, 1, 1,  9, 1, 0, 0, 0), 0, 2, 0};
    vecs[11] = '{mk(1,  1,  0, 1, 0,  0, 1, 1, 0, 0), 0, 0, 0};
    vecs[12] = '{mk(1,  0,  9, 1, 1, 10, 1, 0, 0, 0), 0, 0, 2};
    vecs[13] = '{mk(1,  0,  0, 0, 0, 31, 1, 0, 1, 0), 0, 0, 0};
    vecs[14] = '{mk(1, 31, 31, 1, 1,  2, 1, 0, 0, 0), 0, 3, 3};
    vecs[15] = '{mk(1, 31,  0, 1, 1,  4, 1, 0, 0, 0), 0, 2, 0};
    vecs[16] = '{mk(1,  0,  0, 1, 0,  6, 1, 1, 0, 0), 0, 0, 0};
    vecs[17] = '{mk(1,  6,  4, 1, 1, 11, 1, 0, 0, 1), 0, 0, 0};
    vecs[18] = '{mk(1,  6,  4, 1, 1, 11, 1, 0, 0, 0), 0, 2, 0};
    vecs[19] = '{mk(1, 11, 11, 0, 1, 12, 1, 0, 0, 0), 0, 0, 1};

    // Reset state
    rst_n = 1'b0;
    #12;
    checkOutput("reset_stall", int'(stall), 0);
    checkOutput("reset_sel_a", int'(fwdA), 0);
    checkOutput("reset_sel_b", int'(fwdB), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].s);
      #1;
      checkOutput($sformatf("vec%0d_stall", i), int'(stall), int'(vecs[i].expStall));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_sel_a", i), int'(fwdA), int'(vecs[i].expA));
      checkOutput($sformatf("vec%0d_sel_b", i), int'(fwdB), int'(vecs[i].expB));
    end

    // Asynchronous reset in the middle of a load-use stall
    applyStimulus(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0));
    @(posedge clk); #1;
    applyStimulus(mk(1, 5, 0, 1, 0, 5, 1, 1, 0, 0));
    @(posedge clk); #1;
    checkOutput("pre_rst_lw_sel_a", int'(fwdA), 1);
    applyStimulus(mk(1, 5, 0, 1, 0, 9, 1, 0, 0, 0));
    #1;
    checkOutput("pre_rst_stall", int'(stall), 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_stall", int'(stall), 0);
    checkOutput("async_rst_sel_a", int'(fwdA), 0);
    checkOutput("async_rst_sel_b", int'(fwdB), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(idle);
    modelReset();
    @(posedge clk); #1;
    modelAdvance(idle, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      stim_t s;
      logic  expS, issued;
      logic [2:0] expA, expB;
      s.valid = ($urandom % 8) != 0;
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.urs   = 1'($urandom % 2);
      s.urt   = 1'($urandom % 2);
      s.wa    = 5'($urandom_range(0, 3));
      s.we    = ($urandom % 4) != 0;
      s.load  = s.we && (($urandom % 3) == 0);
      s.link  = !s.load && (($urandom % 8) == 0);
      s.flush = ($urandom % 10) == 0;
      applyStimulus(s);
      #1;
      expS = modelStall(s);
      checkOutput("rand_stall", int'(stall), int'(expS));
      issued = s.valid && !s.flush && !expS;
      expA = issued ? modelCode(s.rs, s.urs) : 3'd0;
      expB = issued ? modelCode(s.rt, s.urt) : 3'd0;
      @(posedge clk); #1;
      checkOutput("rand_sel_a", int'(fwdA), int'(expA));
      checkOutput("rand_sel_b", int'(fwdB), int'(expB));
      modelAdvance(s, issued);
    end

`ifdef FWD_MDU_STALL_EN
    // mult followed by mfhi stalls until the busy counter drains
    begin
      int stallCycles = 0;
      applyStimulus(idle);
      @(posedge clk); #1;
      applyStimulus(mk(1, 1, 2, 1, 1, 0, 0, 0, 0, 0));
      mduStart = 1'b1;
      @(posedge clk); #1;
      applyStimulus(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0));
      mduStart = 1'b0;
      mduRead  = 1'b1;
      for (int i = 0; i < 100; i++) begin
        #1;
        if (!stall) break;
        stallCycles++;
        @(negedge clk);
      end
      checkOutput("mdu_stall_cycles", stallCycles, 32);
      mduRead = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
